// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared MIPS register file constants
package mips_defs;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_ZERO   = 0;

endpackage

// File: rtl/onehot_decoder.sv
// rtl/onehot_decoder.sv - parametrised binary-to-one-hot decoder with enable
module onehot_decoder #(
    parameter int IN_W = 5
) (
    input  logic                 en,
    input  logic [IN_W-1:0]      a,
    output logic [2**IN_W-1:0]   f
);

    // Single bit at position a when enabled, otherwise all zero
    always_comb begin
        f = '0;
        if (en) begin
            f[a] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_onehot_wr.sv
// rtl/regfile_onehot_wr.sv - register file, one-hot decoded write port, two read ports
module regfile_onehot_wr
    import mips_defs::*;
#(
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int DATA_W   = REG_DATA_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [ADDR_W-1:0]       raddr1,
    input  logic [ADDR_W-1:0]       raddr2,
    output logic [DATA_W-1:0]       rdata1,
    output logic [DATA_W-1:0]       rdata2,
    output logic [2**ADDR_W-1:0]    wr_onehot,
    output logic [15:0]             wr_count
);

    localparam int NREGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] mem [NREGS];
    logic [NREGS-1:0]  dec;
    logic [NREGS-1:0]  sel;

    onehot_decoder #(
        .IN_W (ADDR_W)
    ) u_wdec (
        .en (we),
        .a  (waddr),
        .f  (dec)
    );

    // Suppress the register-0 select when it is hardwired to zero
    always_comb begin
        sel = dec;
        if (ZERO_REG != 0) begin
            sel[REG_ZERO] = 1'b0;
        end
    end

    // Storage: each word loads wdata when its select line is set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (sel[i]) begin
                    mem[i] <= wdata;
                end
            end
        end
    end

    // Registered copy of the committed select, visible the cycle after the write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_onehot <= '0;
        end else begin
            wr_onehot <= sel;
        end
    end

    // Saturating count of committed writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count <= '0;
        end else if ((|sel) && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'd1;
        end
    end

    // Read port 1: zero register wins over bypass, bypass wins over storage
    always_comb begin
        rdata1 = mem[raddr1];
        if ((BYPASS != 0) && we && (raddr1 == waddr)) begin
            rdata1 = wdata;
        end
        if ((ZERO_REG != 0) && (raddr1 == ZERO_IDX)) begin
            rdata1 = '0;
        end
    end

    // Read port 2: same priority as port 1
    always_comb begin
        rdata2 = mem[raddr2];
        if ((BYPASS != 0) && we && (raddr2 == waddr)) begin
            rdata2 = wdata;
        end
        if ((ZERO_REG != 0) && (raddr2 == ZERO_IDX)) begin
            rdata2 = '0;
        end
    end

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// tb/tb_regfile_onehot_wr.sv - self-checking bench for regfile_onehot_wr
module tb_regfile_onehot_wr;

    logic        clk;
    logic        rst;

    // Shared stimulus for the two 5/32 instances
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;

    // Stimulus for the 3/8 instance
    logic        we_s;
    logic [2:0]  waddr_s;
    logic [7:0]  wdata_s;
    logic [2:0]  raddr1_s;
    logic [2:0]  raddr2_s;

    logic [31:0] rd1_a, rd2_a, oh_a;
    logic [15:0] cnt_a;
    logic [31:0] rd1_b, rd2_b, oh_b;
    logic [15:0] cnt_b;
    logic [7:0]  rd1_c, rd2_c, oh_c;
    logic [15:0] cnt_c;

    int total = 0;
    int bad   = 0;

    // Instance a: zero register, bypass
    regfile_onehot_wr #(.ADDR_W(5), .DATA_W(32), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_a), .rdata2(rd2_a),
        .wr_onehot(oh_a), .wr_count(cnt_a));

    // Instance b: ordinary register 0, no bypass
    regfile_onehot_wr #(.ADDR_W(5), .DATA_W(32), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_b), .rdata2(rd2_b),
        .wr_onehot(oh_b), .wr_count(cnt_b));

    // Instance c: small 8-register, 8-bit variant
    regfile_onehot_wr #(.ADDR_W(3), .DATA_W(8), .ZERO_REG(1), .BYPASS(1)) dut_c (
        .clk(clk), .rst(rst), .we(we_s), .waddr(waddr_s), .wdata(wdata_s),
        .raddr1(raddr1_s), .raddr2(raddr2_s), .rdata1(rd1_c), .rdata2(rd2_c),
        .wr_onehot(oh_c), .wr_count(cnt_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] mm [3][32];
    int          last [3];
    int          cnt  [3];

    function automatic bit zr(int k);
        return (k != 1);
    endfunction

    function automatic bit byp(int k);
        return (k != 1);
    endfunction

    function automatic logic [31:0] mrd(int k, int we_i, int wa, logic [31:0] wd, int ra);
        if (zr(k) && ra == 0) return 32'd0;
        if (byp(k) && we_i != 0 && ra == wa) return wd;
        return mm[k][ra];
    endfunction

    function automatic logic [31:0] moh(int k);
        if (last[k] < 0) return 32'd0;
        return 32'd1 << last[k];
    endfunction

    function automatic logic [31:0] mcnt(int k);
        return (cnt[k] > 65535) ? 32'd65535 : 32'(cnt[k]);
    endfunction

    function automatic void mwrite(int k, int we_i, int wa, logic [31:0] wd);
        last[k] = -1;
        if (we_i != 0 && !(zr(k) && wa == 0)) begin
            mm[k][wa] = wd;
            last[k]   = wa;
            cnt[k]    = cnt[k] + 1;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 32; i++) mm[k][i] = 32'd0;
                last[k] = -1;
                cnt[k]  = 0;
            end
        end else begin
            mwrite(0, int'(we), int'(waddr), wdata);
            mwrite(1, int'(we), int'(waddr), wdata);
            mwrite(2, int'(we_s), int'(waddr_s), {24'd0, wdata_s});
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("waddr_x", {31'd0, (we === 1'b1) && $isunknown(waddr)}, 32'd0);
        chk("a_rdata1", rd1_a, mrd(0, int'(we), int'(waddr), wdata, int'(raddr1)));
        chk("a_rdata2", rd2_a, mrd(0, int'(we), int'(waddr), wdata, int'(raddr2)));
        chk("a_onehot", oh_a, moh(0));
        chk("a_count", {16'd0, cnt_a}, mcnt(0));
        chk("b_rdata1", rd1_b, mrd(1, int'(we), int'(waddr), wdata, int'(raddr1)));
        chk("b_rdata2", rd2_b, mrd(1, int'(we), int'(waddr), wdata, int'(raddr2)));
        chk("b_onehot", oh_b, moh(1));
        chk("b_count", {16'd0, cnt_b}, mcnt(1));
        chk("c_rdata1", {24'd0, rd1_c}, mrd(2, int'(we_s), int'(waddr_s), {24'd0, wdata_s}, int'(raddr1_s)));
        chk("c_rdata2", {24'd0, rd2_c}, mrd(2, int'(we_s), int'(waddr_s), {24'd0, wdata_s}, int'(raddr2_s)));
        chk("c_onehot", {24'd0, oh_c}, moh(2));
        chk("c_count", {16'd0, cnt_c}, mcnt(2));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus with literal expectations ----------------
    initial begin
        rst = 1'b1;
        we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
        we_s = 1'b0; waddr_s = '0; wdata_s = '0; raddr1_s = '0; raddr2_s = '0;
        repeat (2) step();
        rst = 1'b0;
        step();

        // Everything reads zero after reset
        for (int r = 0; r < 32; r++) begin
            raddr1 = 5'(r);
            raddr2 = 5'(31 - r);
            #1;
            chk("rst_rd1", rd1_a, 32'd0);
            chk("rst_rd2", rd2_a, 32'd0);
            chk("rst_b_rd1", rd1_b, 32'd0);
        end
        chk("rst_oh", oh_a, 32'd0);
        chk("rst_cnt", {16'd0, cnt_a}, 32'd0);

        // Single write to register 5
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        step();
        we = 1'b0; raddr1 = 5'd5;
        #1;
        chk("w5_rd", rd1_a, 32'hDEADBEEF);
        chk("w5_oh", oh_a, 32'h00000020);
        chk("w5_cnt", {16'd0, cnt_a}, 32'd1);
        step();
        chk("w5_oh_clear", oh_a, 32'd0);

        // Write to register 0
        we = 1'b1; waddr = 5'd0; wdata = 32'h12345678; raddr1 = 5'd0;
        #1;
        chk("w0_rd_during", rd1_a, 32'd0);
        chk("w0_b_rd_during", rd1_b, 32'd0);
        step();
        we = 1'b0;
        #1;
        chk("w0_rd_after", rd1_a, 32'd0);
        chk("w0_oh", oh_a, 32'd0);
        chk("w0_cnt", {16'd0, cnt_a}, 32'd1);
        chk("w0_b_rd_after", rd1_b, 32'h12345678);
        chk("w0_b_oh", oh_b, 32'd1);
        chk("w0_b_cnt", {16'd0, cnt_b}, 32'd2);

        // Bypass vs stored value on register 9
        we = 1'b1; waddr = 5'd9; wdata = 32'h1;
        step();
        wdata = 32'hA5A5A5A5; raddr1 = 5'd9; raddr2 = 5'd9;
        #1;
        chk("byp_a_rd1", rd1_a, 32'hA5A5A5A5);
        chk("byp_a_rd2", rd2_a, 32'hA5A5A5A5);
        chk("byp_b_rd1", rd1_b, 32'h1);
        chk("byp_b_rd2", rd2_b, 32'h1);
        step();
        we = 1'b0;
        #1;
        chk("byp_b_rd1_after", rd1_b, 32'hA5A5A5A5);
        chk("byp_b_rd2_after", rd2_b, 32'hA5A5A5A5);

        // Small variant: walk writes through registers 1..7
        for (int i = 1; i < 8; i++) begin
            we_s = 1'b1; waddr_s = 3'(i); wdata_s = 8'(i + 1);
            step();
            chk("c_walk_oh", {24'd0, oh_c}, 32'd1 << i);
        end
        we_s = 1'b0;
        #1;
        chk("c_walk_cnt", {16'd0, cnt_c}, 32'd7);
        for (int i = 0; i < 8; i++) begin
            raddr1_s = 3'(i);
            #1;
            chk("c_walk_rd", {24'd0, rd1_c}, (i == 0) ? 32'd0 : 32'(i + 1));
        end

        // Randomised traffic on all instances
        repeat (400) begin
            we      = 1'($urandom_range(0, 1));
            waddr   = 5'($urandom_range(0, 31));
            wdata   = $urandom;
            raddr1  = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2  = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            we_s    = 1'($urandom_range(0, 1));
            waddr_s = 3'($urandom_range(0, 7));
            wdata_s = 8'($urandom);
            raddr1_s = ($urandom_range(0, 3) == 0) ? waddr_s : 3'($urandom_range(0, 7));
            raddr2_s = 3'($urandom_range(0, 7));
            step();
        end
        we = 1'b0; we_s = 1'b0;

        // Asynchronous reset in the middle of a write to register 3
        we = 1'b1; waddr = 5'd3; wdata = 32'h77;
        step();
        wdata = 32'h55; raddr1 = 5'd3; raddr2 = 5'd3;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_b_rd", rd1_b, 32'd0);
        chk("arst_a_oh", oh_a, 32'd0);
        chk("arst_b_oh", oh_b, 32'd0);
        chk("arst_a_cnt", {16'd0, cnt_a}, 32'd0);
        we = 1'b0;
        #1;
        chk("arst_a_rd", rd1_a, 32'd0);
        step();
        rst = 1'b0;
        step();

        // Saturation of the write counter
        we = 1'b1;
        for (int n = 0; n < 65540; n++) begin
            waddr  = 5'($urandom_range(1, 31));
            wdata  = $urandom;
            raddr1 = 5'($urandom_range(0, 31));
            step();
        end
        we = 1'b0;
        #1;
        chk("sat_a_cnt", {16'd0, cnt_a}, 32'h0000FFFF);
        chk("sat_b_cnt", {16'd0, cnt_b}, 32'h0000FFFF);
        step();
        chk("sat_a_hold", {16'd0, cnt_a}, 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
